mano_control_unit: RTL and testbench

Hardwired control unit for the basic-computer datapath. It owns the sequence counter, runs the fetch, decode and indirect cycles, and executes the memory-reference and a register-reference subset. It drives the per-register LD/INR/CLR strobes, bus select, memory strobes and ALU op consumed by the datapath registers, shared bus and memory. It contains no data storage beyond its own state.

---
 rtl/mano_control_unit.sv | 158 +++++++++++++++
 tb/tb_mano_control_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mano_control_unit.sv
// Hardwired basic-computer controller: sequence counter, fetch/decode/indirect and execute steps.
// Define MANO_INDIRECT_EN to enable the indirect-address fetch at T3 for D0..D6.
module mano_control_unit #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              Initial_Reset,
  input  logic              start,
  input  logic [WORD_W-1:0] ir,
  input  logic              ac_zero,
  input  logic              dr_zero,
  output logic              ar_ld,
  output logic              ar_inr,
  output logic              pc_ld,
  output logic              pc_inr,
  output logic              dr_ld,
  output logic              dr_inr,
  output logic              ac_ld,
  output logic              ac_inr,
  output logic              ac_clr,
  output logic              ir_ld,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [2:0]        bus_sel,
  output logic [1:0]        alu_op,
  output logic [2:0]        sc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_T0 = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
    S_T4 = 3'd4, S_T5 = 3'd5, S_T6 = 3'd6, S_HALT = 3'd7
  } state_t;

  localparam logic [2:0] BUS_AR  = 3'd1;
  localparam logic [2:0] BUS_PC  = 3'd2;
  localparam logic [2:0] BUS_DR  = 3'd3;
  localparam logic [2:0] BUS_AC  = 3'd4;
  localparam logic [2:0] BUS_IR  = 3'd5;
  localparam logic [2:0] BUS_MEM = 3'd7;

  localparam logic [1:0] ALU_DR  = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_ADD = 2'd2;

  state_t     state, state_nxt;
  logic       i_bit;
  logic [7:0] d;
  logic       ind_fetch;
  logic       unused_ir;

  assign unused_ir = ^ir;
  assign halted    = (state == S_HALT);

`ifdef MANO_INDIRECT_EN
  assign ind_fetch = i_bit;
`else
  assign ind_fetch = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (Initial_Reset) begin
      state <= S_HALT;
      i_bit <= 1'b0;
      d     <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T2) begin
        i_bit <= ir[15];
        d     <= 8'b1 << ir[14:12];
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_nxt = state;
    ar_ld  = 1'b0; ar_inr = 1'b0; pc_ld  = 1'b0; pc_inr = 1'b0;
    dr_ld  = 1'b0; dr_inr = 1'b0; ac_ld  = 1'b0; ac_inr = 1'b0;
    ac_clr = 1'b0; ir_ld  = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    bus_sel = 3'd0;
    alu_op  = ALU_DR;
    sc      = (state == S_HALT) ? 3'd0 : 3'(state);

    unique case (state)
      S_HALT: if (start) state_nxt = S_T0;
      S_T0: begin
        bus_sel = BUS_PC; ar_ld = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        bus_sel = BUS_MEM; mem_rd = 1'b1; ir_ld = 1'b1; pc_inr = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        bus_sel = BUS_IR; ar_ld = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (d[7]) begin
          state_nxt = S_T0;
          // Register-reference: any combination of bits acts in the same cycle.
          if (!i_bit) begin
            ac_clr = ir[11];
            ac_inr = ir[5];
            pc_inr = ir[2] & ac_zero;
            if (ir[0]) state_nxt = S_HALT;
          end
        end else begin
          state_nxt = S_T4;
          if (ind_fetch) begin
            bus_sel = BUS_MEM; mem_rd = 1'b1; ar_ld = 1'b1;
          end
        end
      end
      S_T4: begin
        state_nxt = S_T5;
        if (d[0] | d[1] | d[2] | d[6]) begin
          bus_sel = BUS_MEM; mem_rd = 1'b1; dr_ld = 1'b1;
        end else if (d[3]) begin
          bus_sel = BUS_AC; mem_wr = 1'b1; state_nxt = S_T0;
        end else if (d[4]) begin
          bus_sel = BUS_AR; pc_ld = 1'b1; state_nxt = S_T0;
        end else begin
          bus_sel = BUS_PC; mem_wr = 1'b1; ar_inr = 1'b1;
        end
      end
      S_T5: begin
        state_nxt = S_T0;
        if (d[6]) begin
          dr_inr = 1'b1; state_nxt = S_T6;
        end else if (d[5]) begin
          bus_sel = BUS_AR; pc_ld = 1'b1;
        end else begin
          ac_ld  = 1'b1;
          alu_op = d[0] ? ALU_AND : (d[1] ? ALU_ADD : ALU_DR);
        end
      end
      S_T6: begin
        bus_sel = BUS_DR; mem_wr = 1'b1; pc_inr = dr_zero;
        state_nxt = S_T0;
      end
      default: state_nxt = S_HALT;
    endcase

    // Reset forces every strobe low so the datapath's own reset values win.
    if (Initial_Reset) begin
      ar_ld  = 1'b0; ar_inr = 1'b0; pc_ld  = 1'b0; pc_inr = 1'b0;
      dr_ld  = 1'b0; dr_inr = 1'b0; ac_ld  = 1'b0; ac_inr = 1'b0;
      ac_clr = 1'b0; ir_ld  = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      bus_sel = 3'd0;
      alu_op  = 2'd0;
      sc      = 3'd0;
    end
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Scoreboard bench for mano_control_unit: an instruction-level model queues per-cycle expectations,
// a negedge monitor pops and compares them. Honours MANO_INDIRECT_EN like the design.
module tb_mano_control_unit;

  typedef struct packed {
    logic       ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr;
    logic       ac_ld, ac_inr, ac_clr, ir_ld, mem_rd, mem_wr;
    logic [2:0] bus_sel;
    logic [1:0] alu_op;
    logic [2:0] sc;
    logic       halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        Initial_Reset;
  logic        start;
  logic [15:0] ir;
  logic        ac_zero, dr_zero;
  logic        ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr;
  logic        ac_ld, ac_inr, ac_clr, ir_ld, mem_rd, mem_wr;
  logic [2:0]  bus_sel, sc;
  logic [1:0]  alu_op;
  logic        halted;

  int   checks = 0;
  int   failures = 0;
  vec_t exp_q[$];
  vec_t act;

  always #5 clk = ~clk;

  mano_control_unit #(.WORD_W(16)) dut (
    .clk(clk), .Initial_Reset(Initial_Reset), .start(start), .ir(ir),
    .ac_zero(ac_zero), .dr_zero(dr_zero),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .pc_ld(pc_ld), .pc_inr(pc_inr),
    .dr_ld(dr_ld), .dr_inr(dr_inr), .ac_ld(ac_ld), .ac_inr(ac_inr),
    .ac_clr(ac_clr), .ir_ld(ir_ld), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .bus_sel(bus_sel), .alu_op(alu_op), .sc(sc), .halted(halted)
  );

  always_comb begin
    act = '0;
    act.ar_ld = ar_ld;   act.ar_inr = ar_inr; act.pc_ld = pc_ld;   act.pc_inr = pc_inr;
    act.dr_ld = dr_ld;   act.dr_inr = dr_inr; act.ac_ld = ac_ld;   act.ac_inr = ac_inr;
    act.ac_clr = ac_clr; act.ir_ld = ir_ld;   act.mem_rd = mem_rd; act.mem_wr = mem_wr;
    act.bus_sel = bus_sel; act.alu_op = alu_op; act.sc = sc; act.halted = halted;
  end

  task automatic check(input string name, input vec_t got, input vec_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h (sc %0d/%0d bus %0d/%0d alu %0d/%0d halted %b/%b)",
               name, $time, got, want, got.sc, want.sc, got.bus_sel, want.bus_sel,
               got.alu_op, want.alu_op, got.halted, want.halted);
    end
  endtask

  // Monitor: the DUT presents a fresh output vector every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("step", act, exp_q.pop_front());
  end

  function automatic vec_t blank(input int step);
    vec_t v = '0;
    v.sc = 3'(step);
    return v;
  endfunction

  function automatic vec_t halt_vec();
    vec_t v = '0;
    v.halted = 1'b1;
    return v;
  endfunction

  // Instruction-level reference: the micro-operation list of each instruction class.
  task automatic push_instr(input logic [15:0] w, input logic acz, input logic drz,
                            output int len, output bit hlt);
    vec_t e;
    logic [2:0] op = w[14:12];
    logic ind = w[15];
    hlt = 1'b0;
    e = blank(0); e.bus_sel = 3'd2; e.ar_ld = 1'b1; exp_q.push_back(e);
    e = blank(1); e.bus_sel = 3'd7; e.mem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_inr = 1'b1; exp_q.push_back(e);
    e = blank(2); e.bus_sel = 3'd5; e.ar_ld = 1'b1; exp_q.push_back(e);
    e = blank(3);
    if (op == 3'd7) begin
      if (!ind) begin
        e.ac_clr = w[11]; e.ac_inr = w[5]; e.pc_inr = w[2] & acz; hlt = w[0];
      end
      exp_q.push_back(e);
      len = 4;
      return;
    end
`ifdef MANO_INDIRECT_EN
    if (ind) begin e.bus_sel = 3'd7; e.mem_rd = 1'b1; e.ar_ld = 1'b1; end
`endif
    exp_q.push_back(e);
    e = blank(4);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd6: begin e.bus_sel = 3'd7; e.mem_rd = 1'b1; e.dr_ld = 1'b1; end
      3'd3:                   begin e.bus_sel = 3'd4; e.mem_wr = 1'b1; end
      3'd4:                   begin e.bus_sel = 3'd1; e.pc_ld = 1'b1; end
      default:                begin e.bus_sel = 3'd2; e.mem_wr = 1'b1; e.ar_inr = 1'b1; end
    endcase
    exp_q.push_back(e);
    len = 5;
    if (op == 3'd3 || op == 3'd4) return;
    e = blank(5);
    len = 6;
    case (op)
      3'd0: begin e.ac_ld = 1'b1; e.alu_op = 2'd1; end
      3'd1: begin e.ac_ld = 1'b1; e.alu_op = 2'd2; end
      3'd2: begin e.ac_ld = 1'b1; e.alu_op = 2'd0; end
      3'd5: begin e.bus_sel = 3'd1; e.pc_ld = 1'b1; end
      default: e.dr_inr = 1'b1;
    endcase
    exp_q.push_back(e);
    if (op != 3'd6) return;
    e = blank(6); e.bus_sel = 3'd3; e.mem_wr = 1'b1; e.pc_inr = drz;
    exp_q.push_back(e);
    len = 7;
  endtask

  // Called at posedge+1 of an instruction's T0; returns at posedge+1 after its last step.
  task automatic run_instr(input logic [15:0] w, input logic acz, input logic drz, output bit hlt);
    int len;
    ir = w; ac_zero = acz; dr_zero = drz;
    push_instr(w, acz, drz, len, hlt);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic idle_halted(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(halt_vec());
      ir = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    exp_q.push_back(halt_vec());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    bit hlt;
    logic [15:0] w;
    Initial_Reset = 1'b1; start = 1'b0; ir = 16'h0; ac_zero = 1'b0; dr_zero = 1'b0;
    @(posedge clk); #1;
    idle_halted(2);
    Initial_Reset = 1'b0;
    idle_halted(2);
    do_start();

    run_instr(16'h1005, 1'b0, 1'b0, hlt);  // ADD direct
    run_instr(16'hA010, 1'b1, 1'b0, hlt);  // LDA indirect
    run_instr(16'h6030, 1'b0, 1'b1, hlt);  // ISZ, skip
    run_instr(16'h6030, 1'b0, 1'b0, hlt);  // ISZ, no skip
    run_instr(16'h5020, 1'b0, 1'b0, hlt);  // BSA
    run_instr(16'h3040, 1'b0, 1'b0, hlt);  // STA
    run_instr(16'hC050, 1'b0, 1'b0, hlt);  // BUN indirect
    run_instr(16'h0060, 1'b1, 1'b1, hlt);  // AND
    run_instr(16'h7820, 1'b0, 1'b0, hlt);  // CLA+INC
    run_instr(16'h7004, 1'b1, 1'b0, hlt);  // SZA, AC zero
    run_instr(16'h7004, 1'b0, 1'b0, hlt);  // SZA, AC nonzero
    run_instr(16'hF001, 1'b1, 1'b0, hlt);  // I/O: bit 0 must not halt
    run_instr(16'h7001, 1'b0, 1'b0, hlt);  // HLT
    idle_halted(3);
    do_start();

    for (int n = 0; n < 60; n++) begin
      w = 16'($urandom);
      if (w[14:12] == 3'd7 && !w[15] && ($urandom_range(0, 5) != 0)) w[0] = 1'b0;
      run_instr(w, 1'($urandom), 1'($urandom), hlt);
      if (hlt) begin
        idle_halted(2);
        do_start();
      end
    end

    // Reset during ISZ T5 abandons the instruction.
    begin
      int len;
      ir = 16'h6030; dr_zero = 1'b1;
      push_instr(16'h6030, 1'b0, 1'b1, len, hlt);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      exp_q.push_back('0);
      repeat (5) @(posedge clk);
      #1;
      Initial_Reset = 1'b1;
      @(posedge clk); #1;
      Initial_Reset = 1'b0;
      idle_halted(2);
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
